// File: rtl/mips_gpio_mmio.sv
// Memory-mapped GPIO for the CoreMips data bus: synchronised and debounced inputs,
// sticky rising-edge flags with interrupt, and an 8-bit output register.
module mips_gpio_mmio #(
    parameter int DATA_WIDTH      = 32,
    parameter int GPIO_WIDTH      = 8,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sel_i,
    input  logic                  we_i,
    input  logic [3:0]            addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    input  logic [GPIO_WIDTH-1:0] GPIO_i,
    output logic [GPIO_WIDTH-1:0] GPIO_o,
    output logic                  irq_o
);

    localparam logic [7:0] CNT_MAX    = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [1:0] REG_IN     = 2'd0;
    localparam logic [1:0] REG_OUT    = 2'd1;
    localparam logic [1:0] REG_EDGE   = 2'd2;
    localparam logic [1:0] REG_IRQ_EN = 2'd3;

    logic [GPIO_WIDTH-1:0] sync1, sync2;
    logic [GPIO_WIDTH-1:0] in_q, in_d;
    logic [GPIO_WIDTH-1:0] out_q, edge_q, edge_d, irq_en_q;
    logic [7:0]            cnt_q [GPIO_WIDTH];
    logic [7:0]            cnt_d [GPIO_WIDTH];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [GPIO_WIDTH-1:0] wr_bits, edge_clr, read_val;
    logic [1:0]            reg_sel;
    logic                  wr_en, rd_en;
    logic                  unused_bits;

    assign reg_sel     = addr_i[3:2];
    assign wr_en       = sel_i & we_i;
    assign rd_en       = sel_i & ~we_i;
    assign wr_bits     = wdata_i[GPIO_WIDTH-1:0];
    assign unused_bits = ^{addr_i[1:0], wdata_i[DATA_WIDTH-1:GPIO_WIDTH]};

    always_comb begin
        in_d = in_q;
        for (int i = 0; i < GPIO_WIDTH; i++) begin
            cnt_d[i] = cnt_q[i] + 8'd1;
            if (sync2[i] == in_q[i]) begin
                cnt_d[i] = 8'd0;
            end else if (cnt_q[i] == CNT_MAX) begin
                in_d[i]  = sync2[i];
                cnt_d[i] = 8'd0;
            end
        end
    end

    // A flag raised this edge survives a simultaneous write-1-to-clear.
    always_comb begin
        edge_clr = (wr_en && reg_sel == REG_EDGE) ? wr_bits : '0;
        edge_d   = (edge_q & ~edge_clr) | (in_d & ~in_q);
    end

    always_comb begin
        read_val = '0;
        unique case (reg_sel)
            REG_IN:     read_val = in_q;
            REG_OUT:    read_val = out_q;
            REG_EDGE:   read_val = edge_q;
            REG_IRQ_EN: read_val = irq_en_q;
            default:    read_val = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            in_q  <= '0;
            for (int i = 0; i < GPIO_WIDTH; i++) begin
                cnt_q[i] <= 8'd0;
            end
        end else begin
            sync1 <= GPIO_i;
            sync2 <= sync1;
            in_q  <= in_d;
            for (int i = 0; i < GPIO_WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q    <= '0;
            edge_q   <= '0;
            irq_en_q <= '0;
            rdata_q  <= '0;
        end else begin
            edge_q <= edge_d;
            if (wr_en && reg_sel == REG_OUT) begin
                out_q <= wr_bits;
            end
            if (wr_en && reg_sel == REG_IRQ_EN) begin
                irq_en_q <= wr_bits;
            end
            if (rd_en) begin
                rdata_q <= {{(DATA_WIDTH - GPIO_WIDTH){1'b0}}, read_val};
            end
        end
    end

    assign rdata_o = rdata_q;
    assign GPIO_o  = out_q;
    assign irq_o   = |(edge_q & irq_en_q);

endmodule

// File: tb/tb_mips_gpio_mmio.sv
// Self-checking bench for mips_gpio_mmio: read results go through an expected-value
// queue, pin and interrupt levels are checked directly after each clock edge.
module tb_mips_gpio_mmio;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel_i;
    logic        we_i;
    logic [3:0]  addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic [7:0]  GPIO_i;
    logic [7:0]  GPIO_o;
    logic        irq_o;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q [$];

    mips_gpio_mmio #(
        .DATA_WIDTH(32),
        .GPIO_WIDTH(8),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sel_i(sel_i),
        .we_i(we_i),
        .addr_i(addr_i),
        .wdata_i(wdata_i),
        .rdata_o(rdata_o),
        .GPIO_i(GPIO_i),
        .GPIO_o(GPIO_o),
        .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic s, input logic w, input logic [3:0] a, input logic [31:0] d);
        sel_i   = s;
        we_i    = w;
        addr_i  = a;
        wdata_i = d;
        tick();
        sel_i   = 1'b0;
        we_i    = 1'b0;
        addr_i  = 4'h0;
        wdata_i = 32'h0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] e);
        exp_q.push_back(e);
        bus(1'b1, 1'b0, a, 32'h0);
    endtask

    task automatic do_reset(input logic [7:0] g);
        rst    = 1'b1;
        GPIO_i = g;
        sel_i  = 1'b0;
        we_i   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        logic [31:0] e;
        do_reset(8'h00);
        n_checks++;
        if (rdata_o !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_rdata got %h expected %h", rdata_o, 32'h0); end
        n_checks++;
        if (GPIO_o !== 8'h0) begin n_fail++; $display("[TB] FAIL reset_gpio got %h expected %h", GPIO_o, 8'h0); end
        n_checks++;
        if (irq_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_irq got %b expected 0", irq_o); end

        bus(1'b1, 1'b1, 4'h4, 32'h55);
        bus(1'b1, 1'b1, 4'hC, 32'hFF);
        GPIO_i = 8'hFF;
        repeat (8) tick();
        n_checks++;
        if (irq_o !== 1'b1) begin n_fail++; $display("[TB] FAIL pre_reset_irq got %b expected 1", irq_o); end
        rd(4'h4, 32'h55);
        e = exp_q.pop_front();
        n_checks++;
        if (rdata_o !== e) begin n_fail++; $display("[TB] FAIL pre_reset_read got %h expected %h", rdata_o, e); end

        rst = 1'b1;
        #1;
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (rdata_o !== 32'h0 || GPIO_o !== 8'h0 || irq_o !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL in_reset cycle %0d got rdata=%h gpio=%h irq=%b expected all 0", c, rdata_o, GPIO_o, irq_o);
            end
            tick();
        end
        rst = 1'b0;

        for (int k = 1; k <= 7; k++) begin
            rd(4'h0, (k < 7) ? 32'h0 : 32'hFF);
            e = exp_q.pop_front();
            n_checks++;
            if (rdata_o !== e) begin n_fail++; $display("[TB] FAIL reset_in_latency edge %0d got %h expected %h", k, rdata_o, e); end
        end
        rd(4'h8, 32'hFF);
        e = exp_q.pop_front();
        n_checks++;
        if (rdata_o !== e) begin n_fail++; $display("[TB] FAIL reset_edge_after got %h expected %h", rdata_o, e); end
        n_checks++;
        if (irq_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_irq_en_cleared got %b expected 0", irq_o); end
    endtask

    task automatic test_debounce();
        logic [31:0] e;
        do_reset(8'h00);
        GPIO_i = 8'h01;
        for (int k = 1; k <= 7; k++) begin
            rd(4'h0, (k < 7) ? 32'h0 : 32'h1);
            e = exp_q.pop_front();
            n_checks++;
            if (rdata_o !== e) begin n_fail++; $display("[TB] FAIL debounce_latency edge %0d got %h expected %h", k, rdata_o, e); end
        end
        rd(4'h8, 32'h1);
        e = exp_q.pop_front();
        n_checks++;
        if (rdata_o !== e) begin n_fail++; $display("[TB] FAIL debounce_edge got %h expected %h", rdata_o, e); end

        bus(1'b1, 1'b1, 4'h8, 32'h1);
        GPIO_i = 8'h03;
        repeat (3) tick();
        GPIO_i = 8'h01;
        repeat (8) tick();
        rd(4'h0, 32'h1);
        e = exp_q.pop_front();
        n_checks++;
        if (rdata_o !== e) begin n_fail++; $display("[TB] FAIL glitch_in got %h expected %h", rdata_o, e); end
        rd(4'h8, 32'h0);
        e = exp_q.pop_front();
        n_checks++;
        if (rdata_o !== e) begin n_fail++; $display("[TB] FAIL glitch_edge got %h expected %h", rdata_o, e); end
    endtask

    task automatic test_out();
        logic [31:0] e;
        do_reset(8'h00);
        bus(1'b1, 1'b1, 4'h4, 32'hDEADBEA5);
        n_checks++;
        if (GPIO_o !== 8'hA5) begin n_fail++; $display("[TB] FAIL out_pins got %h expected %h", GPIO_o, 8'hA5); end
        rd(4'h4, 32'h000000A5);
        e = exp_q.pop_front();
        n_checks++;
        if (rdata_o !== e) begin n_fail++; $display("[TB] FAIL out_read got %h expected %h", rdata_o, e); end
        rd(4'h7, 32'h000000A5);
        e = exp_q.pop_front();
        n_checks++;
        if (rdata_o !== e) begin n_fail++; $display("[TB] FAIL out_read_low_addr got %h expected %h", rdata_o, e); end
        bus(1'b1, 1'b1, 4'h0, 32'hFFFFFFFF);
        rd(4'h0, 32'h0);
        e = exp_q.pop_front();
        n_checks++;
        if (rdata_o !== e) begin n_fail++; $display("[TB] FAIL in_write_ignored got %h expected %h", rdata_o, e); end
        rd(4'hC, 32'h0);
        e = exp_q.pop_front();
        n_checks++;
        if (rdata_o !== e) begin n_fail++; $display("[TB] FAIL irq_en_untouched got %h expected %h", rdata_o, e); end
    endtask

    task automatic test_edge_irq();
        logic [31:0] e;
        do_reset(8'h00);
        bus(1'b1, 1'b1, 4'hC, 32'h1);
        GPIO_i = 8'h01;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k >= 5) begin
                n_checks++;
                if (irq_o !== (k == 6)) begin n_fail++; $display("[TB] FAIL irq_rise edge %0d got %b expected %b", k, irq_o, (k == 6)); end
            end
        end
        rd(4'h8, 32'h1);
        e = exp_q.pop_front();
        n_checks++;
        if (rdata_o !== e) begin n_fail++; $display("[TB] FAIL edge_set got %h expected %h", rdata_o, e); end
        bus(1'b1, 1'b1, 4'h8, 32'h1);
        n_checks++;
        if (irq_o !== 1'b0) begin n_fail++; $display("[TB] FAIL irq_w1c got %b expected 0", irq_o); end
        rd(4'h8, 32'h0);
        e = exp_q.pop_front();
        n_checks++;
        if (rdata_o !== e) begin n_fail++; $display("[TB] FAIL edge_w1c got %h expected %h", rdata_o, e); end

        GPIO_i = 8'h00;
        repeat (8) tick();
        n_checks++;
        if (irq_o !== 1'b0) begin n_fail++; $display("[TB] FAIL irq_fall got %b expected 0", irq_o); end
        rd(4'h8, 32'h0);
        e = exp_q.pop_front();
        n_checks++;
        if (rdata_o !== e) begin n_fail++; $display("[TB] FAIL edge_fall got %h expected %h", rdata_o, e); end

        GPIO_i = 8'h02;
        repeat (8) tick();
        n_checks++;
        if (irq_o !== 1'b0) begin n_fail++; $display("[TB] FAIL irq_masked got %b expected 0", irq_o); end
        rd(4'h8, 32'h2);
        e = exp_q.pop_front();
        n_checks++;
        if (rdata_o !== e) begin n_fail++; $display("[TB] FAIL edge_masked got %h expected %h", rdata_o, e); end
        bus(1'b1, 1'b1, 4'hC, 32'h2);
        n_checks++;
        if (irq_o !== 1'b1) begin n_fail++; $display("[TB] FAIL irq_enable got %b expected 1", irq_o); end
        bus(1'b1, 1'b1, 4'hC, 32'h0);
        n_checks++;
        if (irq_o !== 1'b0) begin n_fail++; $display("[TB] FAIL irq_disable got %b expected 0", irq_o); end
        bus(1'b1, 1'b1, 4'h8, 32'h0);
        rd(4'h8, 32'h2);
        e = exp_q.pop_front();
        n_checks++;
        if (rdata_o !== e) begin n_fail++; $display("[TB] FAIL edge_write0 got %h expected %h", rdata_o, e); end
    endtask

    task automatic test_simultaneous();
        logic [31:0] e;
        do_reset(8'h00);
        bus(1'b1, 1'b1, 4'hC, 32'h1);
        GPIO_i = 8'h01;
        repeat (5) tick();
        bus(1'b1, 1'b1, 4'h8, 32'h1);
        n_checks++;
        if (irq_o !== 1'b1) begin n_fail++; $display("[TB] FAIL simul_irq got %b expected 1", irq_o); end
        rd(4'h8, 32'h1);
        e = exp_q.pop_front();
        n_checks++;
        if (rdata_o !== e) begin n_fail++; $display("[TB] FAIL simul_edge got %h expected %h", rdata_o, e); end
        bus(1'b1, 1'b1, 4'h8, 32'h1);
        n_checks++;
        if (irq_o !== 1'b0) begin n_fail++; $display("[TB] FAIL simul_clear_irq got %b expected 0", irq_o); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e;
        do_reset(8'h00);
        bus(1'b1, 1'b1, 4'h4, 32'h11);
        rd(4'h4, 32'h11);
        e = exp_q.pop_front();
        n_checks++;
        if (rdata_o !== e) begin n_fail++; $display("[TB] FAIL b2b_first got %h expected %h", rdata_o, e); end
        bus(1'b1, 1'b1, 4'h4, 32'h3C);
        n_checks++;
        if (rdata_o !== 32'h11) begin n_fail++; $display("[TB] FAIL b2b_write_holds got %h expected %h", rdata_o, 32'h11); end
        n_checks++;
        if (GPIO_o !== 8'h3C) begin n_fail++; $display("[TB] FAIL b2b_pins got %h expected %h", GPIO_o, 8'h3C); end
        rd(4'h4, 32'h3C);
        e = exp_q.pop_front();
        n_checks++;
        if (rdata_o !== e) begin n_fail++; $display("[TB] FAIL b2b_new got %h expected %h", rdata_o, e); end
        repeat (3) tick();
        n_checks++;
        if (rdata_o !== 32'h3C) begin n_fail++; $display("[TB] FAIL b2b_idle_holds got %h expected %h", rdata_o, 32'h3C); end
        bus(1'b1, 1'b1, 4'hC, 32'hABCDEF3C);
        rd(4'hC, 32'h3C);
        e = exp_q.pop_front();
        n_checks++;
        if (rdata_o !== e) begin n_fail++; $display("[TB] FAIL b2b_upper_bits got %h expected %h", rdata_o, e); end

        GPIO_i = 8'h04;
        repeat (5) tick();
        rd(4'h8, 32'h0);
        e = exp_q.pop_front();
        n_checks++;
        if (rdata_o !== e) begin n_fail++; $display("[TB] FAIL b2b_edge_old got %h expected %h", rdata_o, e); end
        rd(4'h8, 32'h4);
        e = exp_q.pop_front();
        n_checks++;
        if (rdata_o !== e) begin n_fail++; $display("[TB] FAIL b2b_edge_new got %h expected %h", rdata_o, e); end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout after %0d checks", n_checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst     = 1'b1;
        sel_i   = 1'b0;
        we_i    = 1'b0;
        addr_i  = 4'h0;
        wdata_i = 32'h0;
        GPIO_i  = 8'h00;
        test_reset();
        test_debounce();
        test_out();
        test_edge_irq();
        test_simultaneous();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
